// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage RAM access controller.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_INVALID  = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_WAIT = 2'b01,
    DONE    = 2'b10
  } stateT;

  // The reserved size code behaves as a word access everywhere.
  function automatic logic [1:0] normSize(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_WORD : size;
  endfunction

endpackage

// File: rtl/lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge.
module lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] ldWord,
  input  logic [DATA_W-1:0] stOld,
  input  logic [DATA_W-1:0] stNew,
  input  logic [1:0]        size,
  input  logic [1:0]        offset,
  input  logic              signExt,
  output logic [DATA_W-1:0] ldData,
  output logic [DATA_W-1:0] stWord
);

  localparam int NUM_LANES = DATA_W / 8;

  logic [DATA_W-1:0]    shifted;
  logic [DATA_W-1:0]    repl;
  logic [NUM_LANES-1:0] laneHit;

  assign shifted = ldWord >> {offset, 3'b000};

  always_comb begin
    ldData = shifted;
    repl   = stNew;
    case (size)
      SIZE_BYTE: begin
        ldData = {{(DATA_W-8){signExt & shifted[7]}}, shifted[7:0]};
        repl   = {NUM_LANES{stNew[7:0]}};
      end
      SIZE_HALF: begin
        ldData = {{(DATA_W-16){signExt & shifted[15]}}, shifted[15:0]};
        repl   = {(NUM_LANES/2){stNew[15:0]}};
      end
      default: begin
        ldData = ldWord;
        repl   = stNew;
      end
    endcase
  end

  // New data is replicated across all lanes; the hit mask picks which land.
  for (genvar k = 0; k < NUM_LANES; k++) begin : gLane
    localparam logic [1:0] LANE = 2'(k);
    assign laneHit[k] = (size != SIZE_BYTE && size != SIZE_HALF) ||
                        (size == SIZE_BYTE && offset == LANE) ||
                        (size == SIZE_HALF && offset[1] == LANE[1]);
    assign stWord[8*k +: 8] = laneHit[k] ? repl[8*k +: 8] : stOld[8*k +: 8];
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer to the synchronous data RAM: loads, stores, RMW and faults.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        dataSize,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] physicalAddr,
  input  logic              invalidAddr,
  input  logic [1:0]        byteOffset,
  input  logic [DATA_W-1:0] wrData,
  output logic [DATA_W-1:0] rdData,
  output logic              stall,
  output logic              memFault,
  output logic [1:0]        faultCause,
  output logic              ramEn,
  output logic              ramWe,
  output logic [ADDR_W-1:0] ramAddr,
  output logic [DATA_W-1:0] ramWdata,
  input  logic [DATA_W-1:0] ramRdata
);

  stateT state, nextState;

  logic [ADDR_W-1:0] rAddr;
  logic [1:0]        rSize;
  logic [1:0]        rOff;
  logic              rSext;
  logic [DATA_W-1:0] rData;
  logic              rStore;

  logic [1:0]        sizeN;
  logic              req, isStore, misalign, fault;
  logic              accept, ldCapture;
  logic [1:0]        causeNext;
  logic [DATA_W-1:0] ldData, mergedWord;

  assign sizeN    = normSize(dataSize);
  assign req      = memRead | memWrite;
  assign isStore  = memWrite;
  assign misalign = (sizeN == SIZE_HALF && byteOffset[0]) ||
                    (sizeN == SIZE_WORD && byteOffset != 2'b00);
  assign fault    = invalidAddr | misalign;

  lane_align #(.DATA_W(DATA_W)) uAlign (
    .ldWord  (ramRdata),
    .stOld   (ramRdata),
    .stNew   (rData),
    .size    (rSize),
    .offset  (rOff),
    .signExt (rSext),
    .ldData  (ldData),
    .stWord  (mergedWord)
  );

  // Outputs are held quiet while reset is asserted so a dropped merge never writes.
  always_comb begin
    nextState = state;
    stall     = 1'b0;
    memFault  = 1'b0;
    ramEn     = 1'b0;
    ramWe     = 1'b0;
    ramAddr   = '0;
    ramWdata  = '0;
    accept    = 1'b0;
    ldCapture = 1'b0;
    causeNext = faultCause;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (fault) begin
              memFault  = 1'b1;
              causeNext = invalidAddr ? CAUSE_INVALID : CAUSE_MISALIGN;
            end else if (isStore && sizeN == SIZE_WORD) begin
              ramEn    = 1'b1;
              ramWe    = 1'b1;
              ramAddr  = physicalAddr;
              ramWdata = wrData;
            end else begin
              ramEn     = 1'b1;
              ramAddr   = physicalAddr;
              stall     = 1'b1;
              accept    = 1'b1;
              nextState = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          stall     = 1'b1;
          nextState = DONE;
          if (rStore) begin
            ramEn    = 1'b1;
            ramWe    = 1'b1;
            ramAddr  = rAddr;
            ramWdata = mergedWord;
          end else begin
            ldCapture = 1'b1;
          end
        end
        DONE: nextState = IDLE;
        default: nextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      rAddr      <= '0;
      rSize      <= SIZE_WORD;
      rOff       <= '0;
      rSext      <= 1'b0;
      rData      <= '0;
      rStore     <= 1'b0;
      rdData     <= '0;
      faultCause <= CAUSE_NONE;
    end else begin
      state      <= nextState;
      faultCause <= causeNext;
      if (accept) begin
        rAddr  <= physicalAddr;
        rSize  <= sizeN;
        rOff   <= byteOffset;
        rSext  <= signExt;
        rData  <= wrData;
        rStore <= isStore;
      end
      if (ldCapture) rdData <= ldData;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a behavioural synchronous RAM.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              memRead, memWrite, signExt, invalidAddr;
  logic [1:0]        dataSize, byteOffset;
  logic [ADDR_W-1:0] physicalAddr;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] rdData;
  logic              stall, memFault, ramEn, ramWe;
  logic [1:0]        faultCause;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramWdata, ramRdata;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite),
    .dataSize(dataSize), .signExt(signExt), .physicalAddr(physicalAddr),
    .invalidAddr(invalidAddr), .byteOffset(byteOffset), .wrData(wrData),
    .rdData(rdData), .stall(stall), .memFault(memFault), .faultCause(faultCause),
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWdata(ramWdata),
    .ramRdata(ramRdata)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem [0:2047];
  always @(posedge clk) begin
    if (ramEn) begin
      if (ramWe) mem[ramAddr] <= ramWdata;
      ramRdata <= mem[ramAddr];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrExpT;

  wrExpT       wrQ[$];
  logic [31:0] accQ[$];
  logic [1:0]  faultQ[$];

  int nCmp = 0;
  int nBad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flagFail(input string name);
    nCmp++;
    nBad++;
    $display("FAIL %s: event with no matching expectation", name);
  endtask

  // Monitor: pops expectations as the DUT produces writes, faults and access completions.
  initial begin
    int          stallCnt = 0;
    bit          pend = 1'b0;
    logic [1:0]  pendCause = 2'b00;
    wrExpT       w;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallCnt = 0;
        pend     = 1'b0;
        continue;
      end
      if (pend) begin
        chk("faultCause", 32'(faultCause), 32'(pendCause));
        pend = 1'b0;
      end
      if (memFault) begin
        chk("faultNoRamEn", 32'(ramEn), 32'd0);
        if (faultQ.size() == 0) flagFail("memFault");
        else begin
          pendCause = faultQ.pop_front();
          pend      = 1'b1;
        end
      end
      if (ramEn && ramWe) begin
        if (wrQ.size() == 0) flagFail("ramWrite");
        else begin
          w = wrQ.pop_front();
          chk("ramAddr", 32'(ramAddr), 32'(w.addr));
          chk("ramWdata", ramWdata, w.data);
        end
      end
      if (stall) stallCnt++;
      else if (stallCnt > 0) begin
        if (accQ.size() == 0) flagFail("accessDone");
        else begin
          e = accQ.pop_front();
          chk("stallCycles", 32'(stallCnt), 32'd2);
          chk("rdData", rdData, e);
        end
        stallCnt = 0;
      end
    end
  end

  task automatic idleInputs();
    memRead = 0; memWrite = 0; dataSize = SIZE_WORD; signExt = 0;
    physicalAddr = '0; invalidAddr = 0; byteOffset = 2'b00; wrData = '0;
  endtask

  // Present one request for a single cycle, then wait out any stall and the DONE cycle.
  task automatic access(input logic rd, input logic wr, input logic [1:0] sz, input logic sx,
                        input logic [ADDR_W-1:0] a, input logic inv, input logic [1:0] off,
                        input logic [31:0] d, input logic expStall);
    int n;
    memRead = rd; memWrite = wr; dataSize = sz; signExt = sx;
    physicalAddr = a; invalidAddr = inv; byteOffset = off; wrData = d;
    #1 chk("issueStall", 32'(stall), 32'(expStall));
    @(posedge clk); #1;
    idleInputs();
    n = 0;
    while (stall && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (stall) flagFail("stallTimeout");
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem[7] = 32'h80FF7F01;
    mem[9] = 32'h11223344;
    ramRdata = '0;
    rst = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rstRdData", rdData, 32'd0);
    chk("rstFaultCause", 32'(faultCause), 32'd0);
    chk("rstStall", 32'(stall), 32'd0);
    chk("rstMemFault", 32'(memFault), 32'd0);
    chk("rstRamEn", 32'(ramEn), 32'd0);
    chk("rstRamWe", 32'(ramWe), 32'd0);
    chk("rstRamAddr", 32'(ramAddr), 32'd0);
    chk("rstRamWdata", ramWdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // word store then load
    wrQ.push_back('{addr: 11'd5, data: 32'hDEADBEEF});
    access(0, 1, SIZE_WORD, 0, 11'd5, 0, 2'd0, 32'hDEADBEEF, 0);
    accQ.push_back(32'hDEADBEEF);
    access(1, 0, SIZE_WORD, 0, 11'd5, 0, 2'd0, 32'h0, 1);

    // byte load extension from 0x80FF7F01, lane 3
    accQ.push_back(32'hFFFFFF80);
    access(1, 0, SIZE_BYTE, 1, 11'd7, 0, 2'd3, 32'h0, 1);
    accQ.push_back(32'h00000080);
    access(1, 0, SIZE_BYTE, 0, 11'd7, 0, 2'd3, 32'h0, 1);

    // half store RMW into 0x11223344 upper half; rdData must stay as last load
    wrQ.push_back('{addr: 11'd9, data: 32'hAABB3344});
    accQ.push_back(32'h00000080);
    access(0, 1, SIZE_HALF, 0, 11'd9, 0, 2'd2, 32'h0000AABB, 1);
    accQ.push_back(32'hFFFFAABB);
    access(1, 0, SIZE_HALF, 1, 11'd9, 0, 2'd2, 32'h0, 1);
    accQ.push_back(32'h00003344);
    access(1, 0, SIZE_HALF, 0, 11'd9, 0, 2'd0, 32'h0, 1);

    // byte store lane 1, upper wrData bits must be ignored
    wrQ.push_back('{addr: 11'd7, data: 32'h80FF5A01});
    accQ.push_back(32'h00003344);
    access(0, 1, SIZE_BYTE, 0, 11'd7, 0, 2'd1, 32'h1234565A, 1);
    accQ.push_back(32'h0000005A);
    access(1, 0, SIZE_BYTE, 1, 11'd7, 0, 2'd1, 32'h0, 1);

    // faults
    faultQ.push_back(CAUSE_MISALIGN);
    access(1, 0, SIZE_WORD, 0, 11'd5, 0, 2'd1, 32'h0, 0);
    faultQ.push_back(CAUSE_INVALID);
    access(1, 0, SIZE_HALF, 0, 11'd5, 1, 2'd1, 32'h0, 0);
    faultQ.push_back(CAUSE_MISALIGN);
    access(0, 1, SIZE_HALF, 0, 11'd5, 0, 2'd3, 32'h0, 0);

    // reset during RD_WAIT of a byte store
    memWrite = 1; dataSize = SIZE_BYTE; physicalAddr = 11'd9; byteOffset = 2'd0;
    wrData = 32'h00000077;
    @(posedge clk); #1;
    idleInputs();
    rst = 1'b1;
    #1;
    chk("midRstStall", 32'(stall), 32'd0);
    chk("midRstRdData", rdData, 32'd0);
    chk("midRstRamWe", 32'(ramWe), 32'd0);
    @(posedge clk); #1;
    chk("midRstStall2", 32'(stall), 32'd0);
    chk("midRstRamEn", 32'(ramEn), 32'd0);
    chk("midRstFaultCause", 32'(faultCause), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    chk("midRstNoWrite", mem[9], 32'hAABB3344);
    accQ.push_back(32'h00000044);
    access(1, 0, SIZE_BYTE, 0, 11'd9, 0, 2'd0, 32'h0, 1);

    // simultaneous read+write behaves as a word store
    wrQ.push_back('{addr: 11'd3, data: 32'h12345678});
    access(1, 1, SIZE_WORD, 0, 11'd3, 0, 2'd0, 32'h12345678, 0);
    chk("bothKeepsRdData", rdData, 32'h00000044);
    accQ.push_back(32'h12345678);
    access(1, 0, SIZE_WORD, 0, 11'd3, 0, 2'd0, 32'h0, 1);

    // reserved size code loads a word
    accQ.push_back(32'h80FF5A01);
    access(1, 0, 2'b11, 1, 11'd7, 0, 2'd0, 32'h0, 1);

    repeat (3) @(posedge clk);
    #1;
    chk("wrQDrained", 32'(wrQ.size()), 32'd0);
    chk("accQDrained", 32'(accQ.size()), 32'd0);
    chk("faultQDrained", 32'(faultQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
